// File: rtl/cdb_pkg.sv
// Shared definitions for the common-data-bus arbiter: commit-op encodings,
// payload field widths and the registered payload record.
package cdb_pkg;

  localparam int OP_W   = 3;
  localparam int RD_W   = 5;
  localparam int DATA_W = 32;

  typedef enum logic [OP_W-1:0] {
    OP_WRITE   = 3'b000,
    OP_JUMP    = 3'b001,
    OP_BOTH    = 3'b010,
    OP_LS      = 3'b011,
    OP_NOTHING = 3'b100
  } commit_op_e;

  // Tag and RS index widths are per-instance parameters, so they live outside.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] jump;
  } cdb_payload_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W:0] cand [NUM_REQ];

  // cand[k] = (ptr + k) mod NUM_REQ, using one conditional subtract.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum      = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ? sum - (IDX_W+1)'(NUM_REQ) : sum;
    end
  endgenerate

  // Scan from the far end so the closest candidate to ptr is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        any = 1'b1;
        idx = cand[k][IDX_W-1:0];
      end
    end
    grant = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Arbitrates execution-unit results onto the single registered CDB/ROB port.
// Define CDB_OLDEST_FIRST_EN to pick the oldest tag relative to rob_head instead of round-robin.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ROB_WIDTH = 4,
  parameter int RS_WIDTH  = 2,
  parameter int REQ_IDX_W = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          clear,
  input  logic [ROB_WIDTH-1:0]          rob_head,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ROB_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*3-1:0]          req_op,
  input  logic [NUM_REQ*5-1:0]          req_rd,
  input  logic [NUM_REQ*32-1:0]         req_wdata,
  input  logic [NUM_REQ*32-1:0]         req_jump,
  input  logic [NUM_REQ*RS_WIDTH-1:0]   req_rs_index,
  output logic                          cdb_valid,
  output logic [ROB_WIDTH-1:0]          cdb_tag,
  output logic [2:0]                    cdb_op,
  output logic [4:0]                    cdb_rd,
  output logic [31:0]                   cdb_wdata,
  output logic [31:0]                   cdb_jump,
  output logic [RS_WIDTH-1:0]           cdb_rs_index,
  output logic [REQ_IDX_W-1:0]          cdb_src
);

  logic [REQ_IDX_W-1:0] rr_ptr_reg;
  logic [REQ_IDX_W-1:0] rr_ptr_next;
  logic [NUM_REQ-1:0]   rr_gnt;
  logic [REQ_IDX_W-1:0] rr_idx;
  logic                 rr_any;

  logic [NUM_REQ-1:0]   win_gnt;
  logic [REQ_IDX_W-1:0] win_idx;
  logic                 win_any;
  logic                 grant_en;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (REQ_IDX_W)
  ) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (rr_gnt),
    .idx   (rr_idx),
    .any   (rr_any)
  );

`ifdef CDB_OLDEST_FIRST_EN
  logic [ROB_WIDTH-1:0] age [NUM_REQ];
  logic [ROB_WIDTH-1:0] best_age;
  logic                 unused_rr;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_age
      assign age[gi] = req_tag[gi*ROB_WIDTH +: ROB_WIDTH] - rob_head;
    end
  endgenerate

  // Strict less-than keeps the lowest index on equal ages.
  always_comb begin
    win_any  = 1'b0;
    win_idx  = '0;
    best_age = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && (!win_any || age[i] < best_age)) begin
        win_any  = 1'b1;
        win_idx  = REQ_IDX_W'(i);
        best_age = age[i];
      end
    end
    win_gnt = win_any ? (NUM_REQ'(1) << win_idx) : '0;
  end

  assign unused_rr = ^{rr_gnt, rr_idx, rr_any};
`else
  logic unused_rob_head;

  assign win_gnt         = rr_gnt;
  assign win_idx         = rr_idx;
  assign win_any         = rr_any;
  assign unused_rob_head = ^rob_head;
`endif

  assign grant_en    = rdy_in & ~clear & win_any;
  assign req_ready   = grant_en ? win_gnt : '0;
  assign rr_ptr_next = (win_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + REQ_IDX_W'(1);

  cdb_payload_t         sel_pl;
  logic [ROB_WIDTH-1:0] sel_tag;
  logic [RS_WIDTH-1:0]  sel_rs;

  // One-hot select of the winning slice.
  always_comb begin
    sel_pl  = '0;
    sel_tag = '0;
    sel_rs  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_gnt[i]) begin
        sel_pl.op    = req_op[i*OP_W +: OP_W];
        sel_pl.rd    = req_rd[i*RD_W +: RD_W];
        sel_pl.wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_pl.jump  = req_jump[i*DATA_W +: DATA_W];
        sel_tag      = req_tag[i*ROB_WIDTH +: ROB_WIDTH];
        sel_rs       = req_rs_index[i*RS_WIDTH +: RS_WIDTH];
      end
    end
  end

  logic                 cdb_valid_reg;
  cdb_payload_t         cdb_pl_reg;
  logic [ROB_WIDTH-1:0] cdb_tag_reg;
  logic [RS_WIDTH-1:0]  cdb_rs_reg;
  logic [REQ_IDX_W-1:0] cdb_src_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cdb_valid_reg <= 1'b0;
      cdb_pl_reg    <= '0;
      cdb_tag_reg   <= '0;
      cdb_rs_reg    <= '0;
      cdb_src_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (rdy_in) begin
      cdb_valid_reg <= grant_en;
      if (grant_en) begin
        cdb_pl_reg  <= sel_pl;
        cdb_tag_reg <= sel_tag;
        cdb_rs_reg  <= sel_rs;
        cdb_src_reg <= win_idx;
        rr_ptr_reg  <= rr_ptr_next;
      end
    end
  end

  assign cdb_valid    = cdb_valid_reg;
  assign cdb_tag      = cdb_tag_reg;
  assign cdb_op       = cdb_pl_reg.op;
  assign cdb_rd       = cdb_pl_reg.rd;
  assign cdb_wdata    = cdb_pl_reg.wdata;
  assign cdb_jump     = cdb_pl_reg.jump;
  assign cdb_rs_index = cdb_rs_reg;
  assign cdb_src      = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, corner sequences,
// and randomized traffic against a queue-free arbitration model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N   = 3;
  localparam int RW  = 4;
  localparam int RSW = 2;
  localparam int IW  = 2;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            rdy_in;
  logic            clear;
  logic [RW-1:0]   rob_head;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_tag;
  logic [N*3-1:0]  req_op;
  logic [N*5-1:0]  req_rd;
  logic [N*32-1:0] req_wdata;
  logic [N*32-1:0] req_jump;
  logic [N*RSW-1:0] req_rs_index;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_tag;
  logic [2:0]      cdb_op;
  logic [4:0]      cdb_rd;
  logic [31:0]     cdb_wdata;
  logic [31:0]     cdb_jump;
  logic [RSW-1:0]  cdb_rs_index;
  logic [IW-1:0]   cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .ROB_WIDTH(RW), .RS_WIDTH(RSW), .REQ_IDX_W(IW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .rob_head(rob_head),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_op(req_op),
    .req_rd(req_rd), .req_wdata(req_wdata), .req_jump(req_jump), .req_rs_index(req_rs_index),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_op(cdb_op), .cdb_rd(cdb_rd),
    .cdb_wdata(cdb_wdata), .cdb_jump(cdb_jump), .cdb_rs_index(cdb_rs_index), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  // Per-requester payload held by the bench, packed onto the DUT buses.
  logic [RW-1:0]  p_tag   [N];
  logic [2:0]     p_op    [N];
  logic [4:0]     p_rd    [N];
  logic [31:0]    p_wdata [N];
  logic [31:0]    p_jump  [N];
  logic [RSW-1:0] p_rs    [N];

  always_comb begin
    req_tag = '0; req_op = '0; req_rd = '0; req_wdata = '0; req_jump = '0; req_rs_index = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i*RW +: RW]       = p_tag[i];
      req_op[i*3 +: 3]          = p_op[i];
      req_rd[i*5 +: 5]          = p_rd[i];
      req_wdata[i*32 +: 32]     = p_wdata[i];
      req_jump[i*32 +: 32]      = p_jump[i];
      req_rs_index[i*RSW +: RSW] = p_rs[i];
    end
  end

  typedef struct {
    logic [RW-1:0]  tag;
    logic [2:0]     op;
    logic [4:0]     rd;
    logic [31:0]    wdata;
    logic [31:0]    jump;
    logic [RSW-1:0] rs;
  } pl_t;

  typedef struct {
    logic       rdy;
    logic       clr;
    logic [2:0] valid;
    logic [2:0] exp_ready;
    logic       exp_cv;
    int         exp_src;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic pl_t slice_of(input int i);
    pl_t p;
    p.tag = p_tag[i]; p.op = p_op[i]; p.rd = p_rd[i];
    p.wdata = p_wdata[i]; p.jump = p_jump[i]; p.rs = p_rs[i];
    return p;
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic check_cycle(input string name, input logic [2:0] exp_ready,
                             input logic exp_cv, input int exp_src, input pl_t exp_pl);
    #2;
    chk($sformatf("%s.ready", name), 64'(req_ready), 64'(exp_ready));
    @(posedge clk_in);
    #1;
    cyc++;
    chk($sformatf("%s.cdb_valid", name), 64'(cdb_valid), 64'(exp_cv));
    if (exp_cv) begin
      chk($sformatf("%s.cdb_src", name),   64'(cdb_src),      64'(exp_src));
      chk($sformatf("%s.cdb_tag", name),   64'(cdb_tag),      64'(exp_pl.tag));
      chk($sformatf("%s.cdb_op", name),    64'(cdb_op),       64'(exp_pl.op));
      chk($sformatf("%s.cdb_rd", name),    64'(cdb_rd),       64'(exp_pl.rd));
      chk($sformatf("%s.cdb_wdata", name), 64'(cdb_wdata),    64'(exp_pl.wdata));
      chk($sformatf("%s.cdb_jump", name),  64'(cdb_jump),     64'(exp_pl.jump));
      chk($sformatf("%s.cdb_rs", name),    64'(cdb_rs_index), 64'(exp_pl.rs));
    end
    $display("cyc %0d %s valid=%b ready=%b cdb_valid=%b src=%0d tag=%0h",
             cyc, name, req_valid, req_ready, cdb_valid, cdb_src, cdb_tag);
  endtask

  // Reference arbitration: scan from the pointer modulo N, or oldest tag first.
  function automatic int model_pick(input logic [2:0] v, input int ptr, input logic [RW-1:0] head);
    int best = -1;
    int best_age = 0;
`ifdef CDB_OLDEST_FIRST_EN
    for (int i = 0; i < N; i++) begin
      int age;
      age = (int'(p_tag[i]) - int'(head) + 16) % 16;
      if (v[i] && (best < 0 || age < best_age)) begin
        best = i;
        best_age = age;
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (v[j] && best < 0) best = j;
    end
    best_age = head;
`endif
    return best;
  endfunction

  task automatic do_reset();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  vec_t tbl[17];
  pl_t  zero_pl;
  logic [2:0] pend;
  int   m_ptr;
  logic m_cv;
  int   m_src;
  pl_t  m_pl;

  initial begin
    zero_pl = '{tag: '0, op: '0, rd: '0, wdata: '0, jump: '0, rs: '0};
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; rob_head = '0; req_valid = '0;
    p_tag[0] = 4'd3; p_op[0] = OP_WRITE; p_rd[0] = 5'd1;  p_wdata[0] = 32'h11111111; p_jump[0] = 32'h100; p_rs[0] = 2'd0;
    p_tag[1] = 4'd5; p_op[1] = OP_BOTH;  p_rd[1] = 5'd7;  p_wdata[1] = 32'hDEADBEEF; p_jump[1] = 32'h200; p_rs[1] = 2'd1;
    p_tag[2] = 4'd9; p_op[2] = OP_LS;    p_rd[2] = 5'd31; p_wdata[2] = 32'h33333333; p_jump[2] = 32'h300; p_rs[2] = 2'd3;

    repeat (2) @(posedge clk_in);
    #1;
    chk("reset.cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset.cdb_src",   64'(cdb_src),   64'd0);
    chk("reset.cdb_tag",   64'(cdb_tag),   64'd0);
    chk("reset.cdb_wdata", 64'(cdb_wdata), 64'd0);
    rst_in = 1'b0;

`ifndef CDB_OLDEST_FIRST_EN
    // rdy, clr, valid, exp_ready, exp_cdb_valid, exp_src   (pointer starts at 0)
    tbl[0]  = '{1'b1, 1'b0, 3'b010, 3'b010, 1'b1, 1};
    tbl[1]  = '{1'b1, 1'b0, 3'b111, 3'b100, 1'b1, 2};
    tbl[2]  = '{1'b1, 1'b0, 3'b111, 3'b001, 1'b1, 0};
    tbl[3]  = '{1'b1, 1'b0, 3'b111, 3'b010, 1'b1, 1};
    tbl[4]  = '{1'b1, 1'b0, 3'b111, 3'b100, 1'b1, 2};
    tbl[5]  = '{1'b1, 1'b0, 3'b111, 3'b001, 1'b1, 0};
    tbl[6]  = '{1'b1, 1'b0, 3'b111, 3'b010, 1'b1, 1};
    tbl[7]  = '{1'b1, 1'b1, 3'b111, 3'b000, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 0};
    tbl[9]  = '{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 0};
    tbl[10] = '{1'b0, 1'b0, 3'b111, 3'b000, 1'b0, 0};
    tbl[11] = '{1'b1, 1'b0, 3'b111, 3'b100, 1'b1, 2};
    tbl[12] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 0};
    tbl[13] = '{1'b1, 1'b0, 3'b101, 3'b001, 1'b1, 0};
    tbl[14] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 0};
    tbl[15] = '{1'b1, 1'b0, 3'b100, 3'b100, 1'b1, 2};
    tbl[16] = '{1'b1, 1'b0, 3'b011, 3'b001, 1'b1, 0};
    for (int r = 0; r < 17; r++) begin
      rdy_in = tbl[r].rdy; clear = tbl[r].clr; req_valid = tbl[r].valid;
      check_cycle($sformatf("vec%0d", r), tbl[r].exp_ready, tbl[r].exp_cv, tbl[r].exp_src,
                  slice_of(tbl[r].exp_src));
    end
`else
    // Oldest-first: head 14, tags {2,15,0} -> ages {4,1,2} -> order 1, 2, 0.
    rob_head = 4'd14; p_tag[0] = 4'd2; p_tag[1] = 4'd15; p_tag[2] = 4'd0;
    rdy_in = 1'b1; clear = 1'b0;
    req_valid = 3'b111; check_cycle("old0", 3'b010, 1'b1, 1, slice_of(1));
    req_valid = 3'b101; check_cycle("old1", 3'b100, 1'b1, 2, slice_of(2));
    req_valid = 3'b001; check_cycle("old2", 3'b001, 1'b1, 0, slice_of(0));
    rob_head = 4'd0; p_tag[0] = 4'd3; p_tag[1] = 4'd5; p_tag[2] = 4'd9;
`endif

    // Reset mid-stream: cdb_valid drops without waiting for a clock edge.
    rdy_in = 1'b1; clear = 1'b0; req_valid = 3'b010;
    check_cycle("pre_rst", 3'b010, 1'b1, 1, slice_of(1));
    #2;
    rst_in = 1'b1;
    #1;
    chk("async_rst.cdb_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst.cdb_src",   64'(cdb_src),   64'd0);
    chk("async_rst.cdb_wdata", 64'(cdb_wdata), 64'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    req_valid = 3'b111;
    check_cycle("post_rst", 3'b001, 1'b1, 0, slice_of(0));

    // Randomized traffic; requesters hold valid and payload until granted.
    do_reset();
    m_ptr = 0; m_cv = 1'b0; m_src = 0; m_pl = zero_pl;
    pend = '0;
    for (int t = 0; t < 400; t++) begin
      int win;
      logic [2:0] exp_ready;
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          p_tag[i]   = RW'($urandom);
          p_op[i]    = 3'($urandom_range(0, 4));
          p_rd[i]    = 5'($urandom);
          p_wdata[i] = $urandom;
          p_jump[i]  = $urandom;
          p_rs[i]    = RSW'($urandom);
          pend[i]    = ($urandom_range(0, 2) != 0);
        end
      end
      req_valid = pend;
      rdy_in    = ($urandom_range(0, 7) != 0);
      clear     = ($urandom_range(0, 11) == 0);
      rob_head  = RW'($urandom);
      win = (rdy_in && !clear) ? model_pick(pend, m_ptr, rob_head) : -1;
      exp_ready = (win >= 0) ? 3'(1 << win) : 3'b000;
      if (rdy_in) begin
        if (clear) m_cv = 1'b0;
        else if (win >= 0) begin
          m_cv = 1'b1; m_src = win; m_pl = slice_of(win); m_ptr = (win + 1) % N;
        end else m_cv = 1'b0;
      end
      check_cycle($sformatf("rnd%0d", t), exp_ready, m_cv, m_src, m_pl);
      if (win >= 0) pend[win] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates result writeback from several execution sources (ALU reservation station, load/store buffer, branch unit) onto the single ROB result port (the port carrying tag/op/rd/wdata/jump/rs_index) and the matching wakeup broadcast.
- Grants at most one requester per cycle, round-robin, and presents the winner on a registered common-data-bus (CDB) output one cycle later.
- Sits between the execution units and the ROB. Drops all traffic on the ROB clear (flush) pulse.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ROB_WIDTH, 4, ROB tag width.
- RS_WIDTH, 2, reservation-station index width.
- REQ_IDX_W, 2, width of the round-robin pointer; must satisfy 2^REQ_IDX_W >= NUM_REQ.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-high reset.
- rdy_in  in  1  global enable; when low the block freezes.
- clear  in  1  ROB flush pulse.
- rob_head  in  ROB_WIDTH  current ROB head tag; used only with the optional feature.
- req_valid  in  NUM_REQ  per-requester result valid.
- req_ready  out  NUM_REQ  per-requester grant (combinational, one-hot or zero).
- req_tag  in  NUM_REQ*ROB_WIDTH  packed ROB tags; requester i occupies slice i.
- req_op  in  NUM_REQ*3  packed commit op (WRITE/JUMP/BOTH/LS/NOTHING).
- req_rd  in  NUM_REQ*5  packed destination register.
- req_wdata  in  NUM_REQ*32  packed result value.
- req_jump  in  NUM_REQ*32  packed jump target.
- req_rs_index  in  NUM_REQ*RS_WIDTH  packed RS slot index.
- cdb_valid  out  1  registered winner valid, driving ROB from_rs.
- cdb_tag, cdb_op, cdb_rd, cdb_wdata, cdb_jump, cdb_rs_index  out  ROB_WIDTH/3/5/32/32/RS_WIDTH  registered winner payload.
- cdb_src  out  REQ_IDX_W  index of the winning requester.

Behaviour:
- Reset (async): cdb_valid=0, all cdb_* payload=0, cdb_src=0, rr_ptr=0.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. A requester holds valid and payload stable until granted. req_ready never depends on its own req_valid except through the arbitration.
- Arbitration: scan indices rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ. The first valid index wins. req_ready is one-hot for the winner.
- On a grant, rr_ptr <= (winner+1) mod NUM_REQ; the wrap is explicit and does not rely on a power of two. With no grant, rr_ptr holds.
- Latency: a grant in cycle N gives cdb_valid=1 with that payload in cycle N+1. cdb_valid is a one-cycle pulse per grant. Back-to-back grants give a continuous cdb_valid stream.
- No backpressure from the ROB; the CDB is accepted unconditionally.
- clear=1 (with rdy_in=1): req_ready=0 in that cycle; at the next edge cdb_valid<=0. rr_ptr holds. No request sampled during clear reaches the CDB.
- rdy_in=0: req_ready=0, and all registers (including cdb_valid) hold.
- Requesters with req_valid=0 are never granted. Payload bits of non-winning slices are ignored.
- All requesters valid: each is served exactly once every NUM_REQ cycles (starvation-free).

Optional Feature:
- Macro CDB_OLDEST_FIRST_EN.
- Defined: the winner is the valid requester with the smallest (req_tag - rob_head) mod 2^ROB_WIDTH, i.e. the oldest instruction. Ties go to the lowest index. rr_ptr is still updated but unused.
- Undefined: pure round-robin as above, and rob_head is ignored.

Decomposition:
- Shared package cdb_pkg:
  - op encodings OP_WRITE=3'b000, OP_JUMP=3'b001, OP_BOTH=3'b010, OP_LS=3'b011, OP_NOTHING=3'b100;
  - payload width constants;
  - a cdb_payload struct type.
- One sub-module rr_picker: combinational, inputs req vector and pointer, outputs one-hot grant and encoded index. It is reused by the LSB issue logic.

Test Plan:
- Reset mid-stream: assert rst_in while cdb_valid=1 -> cdb_valid=0 and rr_ptr=0 immediately (asynchronous).
- Single request: req_valid=3'b010 with tag=5 and wdata=32'hDEADBEEF -> req_ready=3'b010 in the same cycle. Next cycle cdb_valid=1, cdb_tag=5, cdb_wdata=DEADBEEF, cdb_src=1. rr_ptr becomes 2.
- All valid, held 6 cycles from rr_ptr=0 -> grant sequence 0,1,2,0,1,2 with cdb_valid continuously 1 from cycle 1.
- Flush: req_valid=3'b111 with clear=1 -> req_ready=0. Next cycle cdb_valid=0. rr_ptr unchanged.
- rdy_in=0 for 3 cycles with requests pending -> no grants, outputs frozen. Resumes with the same winner when rdy_in returns to 1.
- CDB_OLDEST_FIRST_EN defined: rob_head=14, tags {req0=2, req1=15, req2=0} -> req1 granted first, then req2, then req0.
